// File: rtl/fft_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_tx
// Purpose  : Two-bank ping-pong frame buffer that streams FFT bins with their
//            bin index and an end-of-frame marker, gap-free between frames.
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_tx #(
    parameter  int FRAME_LEN = 32,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      fft_data,
    output logic             fft_valid,
    output logic [IDX_W-1:0] freq,
    output logic             fft_fin,
    output logic             ovf
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [31:0]       r_mem [2][FRAME_LEN];
    logic [1:0]        r_full;
    logic              r_wr_bank;
    logic              r_rd_bank;
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_rd_idx;
    logic              r_ovf;

    logic              w_wr_en;
    logic              w_fill;
    logic              w_last_beat;
    logic [1:0]        w_set;
    logic [1:0]        w_clr;
    logic [1:0]        w_full_next;

    // Banks fill and drain strictly alternately, so the write bank is only
    // ever blocked when both banks hold unsent frames.
    assign in_ready    = ~r_full[r_wr_bank];
    assign w_wr_en     = in_valid & in_ready;
    assign w_fill      = w_wr_en & (r_wr_idx == LAST_IDX);
    assign w_last_beat = (r_state == ST_SEND) & (r_rd_idx == LAST_IDX);
    assign w_set       = w_fill      ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_clr       = w_last_beat ? (2'b01 << r_rd_bank) : 2'b00;
    assign w_full_next = (r_full & ~w_clr) | w_set;
    assign ovf         = r_ovf;

    // Storage has no reset; contents are meaningless until a bank is refilled.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][r_wr_idx] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
            r_rd_idx  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_full  <= w_full_next;
            if (in_valid & ~in_ready) begin
                r_ovf <= 1'b1;
            end
            if (w_wr_en) begin
                r_wr_idx <= w_fill ? '0 : r_wr_idx + 1'b1;
                if (w_fill) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_last_beat) begin
                r_rd_idx  <= '0;
                r_rd_bank <= ~r_rd_bank;
            end else if (r_state == ST_SEND) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
        end
    end

    // Looking at next-cycle fullness lets a frame start the cycle after its
    // last word lands, and lets a queued frame follow with no idle beat.
    always_comb begin
        w_state_next = r_state;
        fft_valid    = 1'b0;
        fft_fin      = 1'b0;
        freq         = '0;
        fft_data     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_full_next[r_rd_bank]) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                fft_valid = 1'b1;
                fft_fin   = w_last_beat;
                freq      = r_rd_idx;
                fft_data  = r_mem[r_rd_bank][r_rd_idx];
                if (w_last_beat && !w_full_next[~r_rd_bank]) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_tx
// Purpose  : Self-checking bench for fft_frame_tx: vector table, directed
//            corner cases and randomized traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_tx;

    localparam int N     = 32;
    localparam int NVEC  = 65;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] fft_data;
    logic        fft_valid;
    logic [4:0]  freq;
    logic        fft_fin;
    logic        ovf;

    always #5 clk = ~clk;

    fft_frame_tx #(.FRAME_LEN(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .fft_data (fft_data),
        .fft_valid(fft_valid),
        .freq     (freq),
        .fft_fin  (fft_fin),
        .ovf      (ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: completed frames awaiting or under transmission are
    // kept as one flat word queue (oldest frame first), plus the partial frame.
    logic [31:0] m_done_q[$];
    logic [31:0] m_part_q[$];
    bit          m_sending = 1'b0;
    int          m_pos     = 0;
    bit          m_ovf     = 1'b0;

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        e_ready;
        logic        e_valid;
        logic [4:0]  e_freq;
        logic [31:0] e_data;
        logic        e_fin;
    } vec_t;

    vec_t vt [NVEC];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endfunction

    function automatic void model_edge(logic v, logic [31:0] d, logic r);
        logic [31:0] tmp;
        bit          ready;
        if (r) begin
            m_done_q.delete();
            m_part_q.delete();
            m_sending = 1'b0;
            m_pos     = 0;
            m_ovf     = 1'b0;
            return;
        end
        ready = (m_done_q.size() < 2 * N);
        if (v && !ready) m_ovf = 1'b1;
        if (v && ready) begin
            m_part_q.push_back(d);
            if (m_part_q.size() == N) begin
                foreach (m_part_q[i]) m_done_q.push_back(m_part_q[i]);
                m_part_q.delete();
            end
        end
        if (m_sending) begin
            if (m_pos == N - 1) begin
                for (int i = 0; i < N; i++) tmp = m_done_q.pop_front();
                m_pos     = 0;
                m_sending = (m_done_q.size() != 0);
            end else begin
                m_pos++;
            end
        end else if (m_done_q.size() != 0) begin
            m_sending = 1'b1;
            m_pos     = 0;
        end
    endfunction

    function automatic void check_model();
        check("model in_ready",  32'(in_ready),  32'(m_done_q.size() < 2 * N));
        check("model fft_valid", 32'(fft_valid), 32'(m_sending));
        check("model freq",      32'(freq),      m_sending ? 32'(m_pos) : 32'd0);
        check("model fft_data",  fft_data,       m_sending ? m_done_q[m_pos] : 32'd0);
        check("model fft_fin",   32'(fft_fin),   32'(m_sending && m_pos == N - 1));
        check("model ovf",       32'(ovf),       32'(m_ovf));
    endfunction

    // Called at a falling edge: drive, take one rising edge, sample at the next falling edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r);
        in_valid = v;
        in_data  = d;
        rst      = r;
        @(posedge clk);
        model_edge(v, d, r);
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int k;
        int cyc;
        int beats;
        int fins;
        int first_v;
        int last_v;
        int ready_low;
        int vcount;
        bit got10;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'd0;
        @(negedge clk);

        // ---------------- single frame vector table ----------------
        vt[0] = '{v: 1'b0, d: 32'd0, r: 1'b1, e_ready: 1'b1, e_valid: 1'b0,
                  e_freq: 5'd0, e_data: 32'd0, e_fin: 1'b0};
        for (int i = 1; i <= N; i++) begin
            vt[i] = '{v: 1'b1, d: 32'h1000 + 32'(i - 1), r: 1'b0, e_ready: 1'b1,
                      e_valid: (i == N), e_freq: 5'd0,
                      e_data: (i == N) ? 32'h1000 : 32'd0, e_fin: 1'b0};
        end
        for (int i = N + 1; i < NVEC; i++) begin
            int b;
            b = i - N;
            vt[i] = '{v: 1'b0, d: 32'd0, r: 1'b0, e_ready: 1'b1,
                      e_valid: (b <= N - 1), e_freq: (b <= N - 1) ? 5'(b) : 5'd0,
                      e_data: (b <= N - 1) ? 32'h1000 + 32'(b) : 32'd0,
                      e_fin: (b == N - 1)};
        end
        for (int i = 0; i < NVEC; i++) begin
            cycle(vt[i].v, vt[i].d, vt[i].r);
            check($sformatf("vec[%0d] in_ready", i),  32'(in_ready),  32'(vt[i].e_ready));
            check($sformatf("vec[%0d] fft_valid", i), 32'(fft_valid), 32'(vt[i].e_valid));
            check($sformatf("vec[%0d] freq", i),      32'(freq),      32'(vt[i].e_freq));
            check($sformatf("vec[%0d] fft_data", i),  fft_data,       vt[i].e_data);
            check($sformatf("vec[%0d] fft_fin", i),   32'(fft_fin),   32'(vt[i].e_fin));
            check($sformatf("vec[%0d] ovf", i),       32'(ovf),       32'd0);
        end

        // ---------------- back-to-back 96 words ----------------
        cycle(1'b0, 32'd0, 1'b1);
        k = 0; cyc = 0; beats = 0; fins = 0; first_v = -1; last_v = -1; ready_low = 0;
        while ((k < 3 * N || fft_valid) && cyc < 400) begin
            logic v;
            v = (k < 3 * N) && in_ready;
            if (k < 3 * N && !in_ready) ready_low++;
            cycle(v, 32'h2000 + 32'(k), 1'b0);
            if (v) begin
                k++;
                if (k == 2 * N) begin
                    check("fill/finish same edge valid", 32'(fft_valid), 32'd1);
                    check("fill/finish same edge freq",  32'(freq),      32'd0);
                    check("fill/finish same edge data",  fft_data,       32'h2000 + 32'(N));
                end
            end
            if (fft_valid) begin
                beats++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            if (fft_fin) fins++;
            cyc++;
        end
        check("b2b terminated", 32'(cyc < 400), 32'd1);
        check("b2b beats",      32'(beats), 32'(3 * N));
        check("b2b frames",     32'(fins),  32'd3);
        check("b2b no gap",     32'(last_v - first_v + 1), 32'(3 * N));
        check("b2b ready low",  32'(ready_low), 32'd0);
        check("b2b ovf",        32'(ovf), 32'd0);

        // ---------------- continuous offer, overflow attempt ----------------
        cycle(1'b0, 32'd0, 1'b1);
        ready_low = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, $urandom, 1'b0);
            if (!in_ready) ready_low++;
        end
        check("sustained ready low", 32'(ready_low), 32'd0);
        check("sustained ovf",       32'(ovf),       32'd0);
        repeat (40) cycle(1'b0, 32'd0, 1'b0);

        // ---------------- partial frame held ----------------
        cycle(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'h3000 + 32'(i), 1'b0);
        vcount = 0;
        repeat (100) begin
            cycle(1'b0, 32'd0, 1'b0);
            if (fft_valid) vcount++;
        end
        check("partial held", 32'(vcount), 32'd0);
        for (int i = 20; i < N; i++) cycle(1'b1, 32'h3000 + 32'(i), 1'b0);
        check("partial first beat", 32'(fft_valid && freq == 5'd0), 32'd1);
        repeat (20) cycle(1'b0, 32'd0, 1'b0);
        check("partial freq20",  32'(freq), 32'd20);
        check("partial word20",  fft_data,  32'h3000 + 32'd20);
        repeat (12) cycle(1'b0, 32'd0, 1'b0);
        check("partial done", 32'(fft_valid), 32'd0);

        // ---------------- reset mid-send ----------------
        cycle(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < N; i++) cycle(1'b1, 32'h4000 + 32'(i), 1'b0);
        got10 = (fft_valid && freq == 5'd10);
        for (int w = 0; w < 64 && !got10; w++) begin
            cycle(1'b0, 32'd0, 1'b0);
            got10 = (fft_valid && freq == 5'd10);
        end
        check("reach freq10", 32'(got10), 32'd1);
        cycle(1'b0, 32'd0, 1'b1);
        check("rst mid-send valid", 32'(fft_valid), 32'd0);
        check("rst mid-send ovf",   32'(ovf),       32'd0);
        check("rst mid-send ready", 32'(in_ready),  32'd1);
        for (int i = 0; i < N; i++) cycle(1'b1, 32'h5000 + 32'(i), 1'b0);
        check("post-rst beat0 valid", 32'(fft_valid), 32'd1);
        check("post-rst beat0 freq",  32'(freq),      32'd0);
        check("post-rst beat0 data",  fft_data,       32'h5000);
        repeat (N + 2) cycle(1'b0, 32'd0, 1'b0);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            logic v;
            logic r;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 599) == 0);
            cycle(v, $urandom, r);
        end
        repeat (2 * N + 4) cycle(1'b0, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_tx.md
FFT_FRAME_TX -- requirements
Module: fft_frame_tx

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 32, giving the number of bins per frame, with FRAME_LEN = 2^5.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data carries a bin this cycle.
REQ-005 SHALL have port in_data, input, 32 bits: packed bin word, opaque to this block.
REQ-006 SHALL have port in_ready, output, 1 bit: a write bank is free, so in_data is accepted this cycle.
REQ-007 SHALL have port fft_data, output, 32 bits: streamed bin word.
REQ-008 SHALL have port fft_valid, output, 1 bit: fft_data, freq and fft_fin are valid this cycle.
REQ-009 SHALL have port freq, output, 5 bits: bin index of fft_data, 0..31.
REQ-010 SHALL have port fft_fin, output, 1 bit: last bin of the frame, asserted only with freq = 31.
REQ-011 SHALL have port ovf, output, 1 bit: sticky flag, set when in_valid is high while in_ready is low.

Function
REQ-012 SHALL buffer frames in two 32x32 banks (ping-pong): one bank is written while the other is streamed.
REQ-013 SHALL accept a word on each rising edge where in_valid and in_ready are both high.
- The word is stored at write index wr_idx in the current write bank.
- wr_idx then increments.
REQ-014 SHALL mark the write bank full when the 32nd word is accepted, with wr_idx wrapping 31 -> 0.
- The write side then switches to the other bank if that bank is empty.
REQ-015 SHALL hold in_ready low whenever both banks are full, and high otherwise.
REQ-016 SHALL drop any word offered while in_ready is low, leaving buffer contents unchanged, and set ovf, which stays set until rst.
REQ-017 SHALL implement the transmit FSM with states IDLE and SEND:
- IDLE -> SEND when a full bank exists.
- SEND -> IDLE after the beat with freq = 31 if no other bank is full.
- SEND -> SEND with freq restarting at 0 if the other bank is full, giving no gap between frames.
REQ-018 SHALL produce the first beat (fft_valid = 1, freq = 0) on the cycle after the edge that accepted the 32nd word.
- The SEND-entry latency is therefore exactly 1 cycle.
REQ-019 SHALL emit one beat per cycle in SEND, with no stalls:
- freq increments 0..31.
- fft_data equals the word written at index freq of the bank being sent.
REQ-020 SHALL assert fft_fin for exactly one cycle per frame, on the beat with freq = 31.
REQ-021 SHALL mark a bank empty on the edge ending its freq = 31 beat, so it becomes writable on the following cycle.
REQ-022 SHALL hold fft_valid, fft_fin, freq and fft_data at 0 in IDLE and whenever fft_valid is low.
REQ-023 SHALL send frames in fill order (first filled, first sent) and SHALL never reorder them.
REQ-024 SHALL support a write to one bank and a read from the other in the same cycle with no interaction.
- A bank finishing its send on the same edge that the other bank fills SHALL NOT drop either frame.
REQ-025 SHALL keep a partially written frame (wr_idx != 0) held indefinitely; it is not sent until complete.

Reset
REQ-026 SHALL, on any rising edge with rst = 1, including mid-frame or mid-send:
- set FSM = IDLE, both banks empty, wr_idx = 0 and write bank = bank 0;
- drive fft_valid = 0, fft_fin = 0, freq = 0, fft_data = 0 and ovf = 0.
REQ-027 SHALL have in_ready = 1 on the first cycle after rst deasserts.
REQ-028 SHALL treat bank storage contents as don't-care after reset.

Verification
REQ-029 Single frame: write words 0x1000+k for k = 0..31 back-to-back -> on the next cycle, 32 beats with freq = k, fft_data = 0x1000+k, fft_fin only at k = 31, then fft_valid = 0.
REQ-030 Back-to-back: stream 96 words continuously -> three frames sent with no idle cycle between frames 1 and 2, in_ready dropping only while both banks are full, and ovf = 0.
REQ-031 Overflow: fill both banks, then hold in_valid = 1 for 1 cycle while in_ready = 0 -> ovf = 1 and persists, dropped word absent from all output frames, both stored frames intact.
REQ-032 Partial frame: write 20 words and then stop -> fft_valid stays 0 for 100 cycles; write 12 more -> full frame sent, with word 20 at freq = 20.
REQ-033 Reset mid-send: assert rst during freq = 10 of a frame -> next cycle fft_valid = 0, ovf = 0, in_ready = 1; a new 32-word frame then sends correctly starting from freq = 0.
REQ-034 Simultaneous fill/finish: time the 32nd write of frame 2 on the same edge as the freq = 31 beat of frame 1 -> frame 2 begins at freq = 0 on the next cycle.
